// File: rtl/mfilter_pkg.sv
// Shared constants for the matched-filter MAC: tap count, window tap-select
// codes, accumulator width and the FSM state encoding.
package mfilter_pkg;

  localparam int NUM_TAPS  = 6;
  localparam int SAMP_W    = 16;
  localparam int PROD_W    = 2 * SAMP_W;
  localparam int ACC_W     = 35;
  localparam int TAP_IDX_W = 3;

  localparam logic [TAP_IDX_W-1:0] LAST_TAP = TAP_IDX_W'(NUM_TAPS - 1);

  localparam logic [2:0] IDLE_SEL = 3'b000;

  // Window addressing is not linear; tap 0 is the newest sample.
  localparam logic [2:0] TAP_SEL [NUM_TAPS] = '{
    3'b011, 3'b010, 3'b101, 3'b100, 3'b111, 3'b110
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] tap_sel(input logic [TAP_IDX_W-1:0] k);
    if (k < TAP_IDX_W'(NUM_TAPS)) begin
      return TAP_SEL[k];
    end
    return IDLE_SEL;
  endfunction

endpackage

// File: rtl/mfilter_coef_bank.sv
// Six signed 16-bit coefficient registers with one write port and a
// combinational read addressed by the current tap index.
module mfilter_coef_bank
  import mfilter_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_we,
  input  logic [TAP_IDX_W-1:0]        i_waddr,
  input  logic signed [SAMP_W-1:0]    i_wdata,
  input  logic [TAP_IDX_W-1:0]        i_raddr,
  output logic signed [SAMP_W-1:0]    o_rdata
);

  logic signed [SAMP_W-1:0] r_coef [NUM_TAPS];

  // Writes to indices 6 and 7 fall outside the bank and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_coef[i] <= '0;
      end
    end else if (i_we && (i_waddr < TAP_IDX_W'(NUM_TAPS))) begin
      r_coef[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr < TAP_IDX_W'(NUM_TAPS)) ? r_coef[i_raddr] : '0;

endmodule

// File: rtl/mfilter_mac.sv
// Six-tap matched-filter multiply-accumulate with saturated result.
// Threshold match compare is built only when MFILTER_THRESHOLD_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for rxstrobe, sel parked at 000
//   MAC   | one tap per cycle: acc += data * coef[tap], busy high
//   DONE  | result_valid pulse; a strobe here starts the next window directly
module mfilter_mac
  import mfilter_pkg::*;
#(
  parameter int OUT_W = 32
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rxstrobe,
  output logic [2:0]               sel,
  input  logic signed [SAMP_W-1:0] data,
  input  logic                     coef_we,
  input  logic [TAP_IDX_W-1:0]     coef_addr,
  input  logic signed [SAMP_W-1:0] coef_data,
  input  logic signed [OUT_W-1:0]  thresh,
  output logic signed [OUT_W-1:0]  result,
  output logic                     result_valid,
  output logic                     match,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                   r_state;
  logic [TAP_IDX_W-1:0]     r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic [2:0]               r_sel;
  logic signed [OUT_W-1:0]  r_result;
  logic                     r_valid;
  logic                     r_match;
  logic                     r_busy;
  logic                     r_overrun;

  logic signed [SAMP_W-1:0] w_coef;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [OUT_W-1:0]  w_sat;
  logic                     w_match;
  logic [TAP_IDX_W-1:0]     w_tap_next;

  mfilter_coef_bank u_coef_bank (
    .clk     (clk),
    .reset   (reset),
    .i_we    (coef_we),
    .i_waddr (coef_addr),
    .i_wdata (coef_data),
    .i_raddr (r_tap),
    .o_rdata (w_coef)
  );

  assign w_prod     = data * w_coef;
  assign w_acc_next = r_acc + ACC_W'(w_prod);
  assign w_tap_next = r_tap + TAP_IDX_W'(1);

  // Saturation is applied to the full sum including the last product.
  always_comb begin
    if (w_acc_next > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_acc_next < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end else begin
      w_sat = w_acc_next[OUT_W-1:0];
    end
  end

`ifdef MFILTER_THRESHOLD_EN
  assign w_match = (w_sat >= thresh);
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^thresh;
  assign w_match = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tap     <= '0;
      r_acc     <= '0;
      r_sel     <= IDLE_SEL;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_match   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_match <= 1'b0;
      if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
      case (r_state)
        IDLE, DONE: begin
          if (rxstrobe) begin
            r_state <= MAC;
            r_tap   <= '0;
            r_acc   <= '0;
            r_sel   <= tap_sel('0);
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_sel   <= IDLE_SEL;
            r_busy  <= 1'b0;
          end
        end
        MAC: begin
          if (rxstrobe) begin
            // Window moved under us: drop this sum; set beats a same-cycle clear.
            r_overrun <= 1'b1;
            r_tap     <= '0;
            r_acc     <= '0;
            r_sel     <= tap_sel('0);
          end else if (r_tap == LAST_TAP) begin
            r_state  <= DONE;
            r_acc    <= w_acc_next;
            r_result <= w_sat;
            r_valid  <= 1'b1;
            r_match  <= w_match;
            r_busy   <= 1'b0;
            r_sel    <= IDLE_SEL;
          end else begin
            r_acc <= w_acc_next;
            r_tap <= w_tap_next;
            r_sel <= tap_sel(w_tap_next);
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= IDLE_SEL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel          = r_sel;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign match        = r_match;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_mfilter_mac.sv
// Scoreboard bench for mfilter_mac: a window-register model feeds data by sel,
// a dot-product reference predicts each result, a monitor checks on result_valid.
`timescale 1ns/1ps
module tb_mfilter_mac;

  localparam int OUT_W = 32;
  localparam longint SMAX = (longint'(1) <<< 31) - 1;
  localparam longint SMIN = -(longint'(1) <<< 31);
`ifdef MFILTER_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    rxstrobe;
  logic [2:0]              sel;
  logic signed [15:0]      data;
  logic                    coef_we;
  logic [2:0]              coef_addr;
  logic signed [15:0]      coef_data;
  logic signed [OUT_W-1:0] thresh;
  logic signed [OUT_W-1:0] result;
  logic                    result_valid;
  logic                    match;
  logic                    busy;
  logic                    overrun;
  logic                    overrun_clr;

  mfilter_mac #(.OUT_W(OUT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rxstrobe     (rxstrobe),
    .sel          (sel),
    .data         (data),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .thresh       (thresh),
    .result       (result),
    .result_valid (result_valid),
    .match        (match),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Upstream six-deep window register, addressed by the DUT's sel.
  logic signed [15:0] din;
  logic signed [15:0] env_win [6];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) env_win[i] <= '0;
    end else if (rxstrobe) begin
      env_win[0] <= din;
      for (int i = 1; i < 6; i++) env_win[i] <= env_win[i-1];
    end
  end

  always_comb begin
    case (sel)
      3'b011:  data = env_win[0];
      3'b010:  data = env_win[1];
      3'b101:  data = env_win[2];
      3'b100:  data = env_win[3];
      3'b111:  data = env_win[4];
      3'b110:  data = env_win[5];
      default: data = 16'sh0;
    endcase
  end

  typedef struct {
    longint res;
    bit     m;
    int     due;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     n_tests = 0;
  int     n_fail  = 0;
  longint mcoef [6];
  longint mwin  [6];
  int     last_s = -1000;
  bit     exp_ovr = 1'b0;
  logic [2:0] exp_sel [6];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  always @(negedge clk) begin
    if (result_valid) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d with no result pending (cycle %0d)", result, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("result", result, mon_e.res);
        check("match", match, longint'(mon_e.m));
        check("latency", cyc, mon_e.due);
      end
    end else begin
      if (match) begin
        n_tests++;
        n_fail++;
        $display("FAIL match_without_valid: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        mon_e = sbq.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missing_result: got none expected %0d due cycle %0d", mon_e.res, mon_e.due);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic signed [15:0] d);
    coef_addr = a;
    coef_data = d;
    coef_we   = 1'b1;
    if (a < 3'd6) mcoef[a] = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  // Strobe sampled on the next edge; the model predicts abort/overrun from spacing.
  task automatic strobe(input logic signed [15:0] s, input bit clr = 1'b0);
    int     se;
    longint acc;
    exp_t   e;
    se = cyc + 1;
    if (se - last_s < 7) begin
      if (sbq.size() != 0 && sbq[$].due == last_s + 6) void'(sbq.pop_back());
      exp_ovr = 1'b1;
    end else if (clr) begin
      exp_ovr = 1'b0;
    end
    for (int i = 5; i > 0; i--) mwin[i] = mwin[i-1];
    mwin[0] = s;
    acc = 0;
    for (int k = 0; k < 6; k++) acc += mwin[k] * mcoef[k];
    e.res = sat(acc);
    e.m   = THR_EN && (e.res >= longint'(thresh));
    e.due = cyc + 7;
    sbq.push_back(e);
    last_s = se;
    din = s;
    rxstrobe = 1'b1;
    overrun_clr = clr;
    @(posedge clk);
    #1;
    rxstrobe = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due > cyc) sbq.delete(i);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mcoef[i] = 0;
      mwin[i] = 0;
    end
    last_s = -1000;
    exp_ovr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_result"}, result, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_sel"}, sel, 0);
  endtask

  initial begin
    reset = 1'b1;
    rxstrobe = 1'b0;
    din = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    thresh = '0;
    overrun_clr = 1'b0;
    exp_sel = '{3'b011, 3'b010, 3'b101, 3'b100, 3'b111, 3'b110};
    for (int i = 0; i < 6; i++) begin
      mcoef[i] = 0;
      mwin[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    // Single-tap coefficient, sel walk and busy window.
    wr_coef(3'd0, 16'sd1);
    strobe(16'sd100);
    for (int i = 0; i < 6; i++) begin
      check("sel_walk", sel, exp_sel[i]);
      check("busy_mac", busy, 1);
      idle(1);
    end
    check("sel_done", sel, 0);
    check("busy_done", busy, 0);
    check("result_100", result, 100);
    idle(3);

    // All-ones coefficients, samples 1..6 at period 8, two thresholds.
    for (int t = 21; t <= 22; t++) begin
      do_reset();
      thresh = t;
      for (int k = 0; k < 6; k++) wr_coef(3'(k), 16'sd1);
      for (int v = 1; v <= 6; v++) begin
        strobe(16'(v));
        idle(7);
      end
      check("sum21", result, 21);
    end

    // Saturation both ways; period 7 also exercises the strobe-at-DONE path.
    do_reset();
    thresh = '0;
    for (int k = 0; k < 6; k++) wr_coef(3'(k), 16'sh8000);
    for (int v = 0; v < 6; v++) begin
      strobe(16'sh8000);
      idle(6);
    end
    idle(1);
    check("sat_max", result, SMAX);
    for (int k = 0; k < 6; k++) wr_coef(3'(k), 16'sh7FFF);
    strobe(16'sh8000);
    idle(7);
    check("sat_min", result, SMIN);

    // Strobe at t3 aborts, then clear, then set-beats-clear.
    do_reset();
    for (int k = 0; k < 6; k++) wr_coef(3'(k), 16'($urandom_range(0, 200)));
    strobe(16'sd7);
    idle(2);
    strobe(16'sd9);
    check("overrun_set", overrun, longint'(exp_ovr));
    idle(7);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    check("overrun_clr", overrun, longint'(exp_ovr));
    strobe(16'sd3);
    idle(2);
    strobe(16'sd4, 1'b1);
    check("overrun_set_wins", overrun, longint'(exp_ovr));
    idle(7);

    // Reset at t4 of a MAC, then a normal computation.
    strobe(16'sd55);
    idle(3);
    do_reset();
    check_all_zero("midreset");
    wr_coef(3'd2, -16'sd3);
    wr_coef(3'd0, 16'sd2);
    strobe(16'sd10);
    strobe(16'sd20);
    idle(6);
    strobe(16'sd30);
    idle(7);
    check("post_reset_calc", result, -30 + 60);

    // Randomized traffic.
    do_reset();
    thresh = '0;
    for (int n = 0; n < 400; n++) begin
      if ((cyc + 1 >= last_s + 6) && ($urandom_range(0, 3) == 0)) begin
        wr_coef(3'($urandom_range(0, 7)), 16'($urandom));
      end
      strobe(16'($urandom), ($urandom_range(0, 3) == 0));
      check("rand_overrun", overrun, longint'(exp_ovr));
      idle($urandom_range(0, 10));
    end
    idle(10);
    check("queue_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
